dual_port_ram: RTL and testbench



---
 rtl/dual_port_ram.sv | 60 ++++++
 tb/tb_dual_port_ram.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
// Optional build macro DPRAM_BYPASS_EN selects write-first on a same-address collision.
module dual_port_ram #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] dout_d;
  logic                  collide;

`ifdef DPRAM_BYPASS_EN
  // Write-first: a same-edge write to the read address forwards the new data.
  assign collide = we & re & (wr_addr == rd_addr);
`else
  // Read-first: the read always sees the pre-edge array contents.
  assign collide = 1'b0;
`endif

  always_comb begin
    dout_d = dout_q;
    if (re) begin
      dout_d = collide ? din : mem_q[rd_addr];
    end
  end

  // Storage is flops so the whole array can clear asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[wr_addr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_dual_port_ram.sv
// Randomized self-checking bench for dual_port_ram against an array-based reference model.
// Build with DPRAM_BYPASS_EN defined to check the write-first collision behaviour.
module tb_dual_port_ram;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;
`ifdef DPRAM_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          we;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] din;
  logic          re;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] dout;

  logic [DW-1:0] ref_mem [8];
  logic [DW-1:0] exp_dout;
  int            n_checks;
  int            n_fail;

  dual_port_ram #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .wr_addr(wr_addr),
    .din    (din),
    .re     (re),
    .rd_addr(rd_addr),
    .dout   (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    exp_dout = '0;
  endtask

  // One clock cycle: drive on the falling edge, update model and compare just after the rise.
  task automatic step(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] d,
                      input logic r, input logic [AW-1:0] ra, input string tag);
    @(negedge clk);
    we = w; wr_addr = wa; din = d; re = r; rd_addr = ra;
    @(posedge clk);
    #1;
    if (r) exp_dout = (Bypass && w && (wa == ra)) ? d : ref_mem[ra];
    if (w) ref_mem[wa] = d;
    check_eq(tag, dout, exp_dout);
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    we = 1'b0; re = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; we = 1'b0; re = 1'b0; wr_addr = '0; rd_addr = '0; din = '0;
    model_clear();
    #12;
    check_eq("reset_dout", dout, '0);
    @(negedge clk);
    rst = 1'b0;

    // Fill and read back
    for (int i = 0; i < 8; i++) step(1'b1, AW'(i), DW'(i), 1'b0, '0, "fill_wr");
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0, '0, 1'b1, AW'(i), "fill_rd");
      check_eq("fill_rd_const", dout, DW'(i));
    end

    // Read enable hold
    step(1'b1, 3'd3, 16'hABCD, 1'b0, '0, "hold_wr");
    step(1'b0, '0, '0, 1'b1, 3'd3, "hold_rd");
    step(1'b0, '0, '0, 1'b0, 3'd5, "hold_re0");
    check_eq("hold_const", dout, 16'hABCD);

    // Write disable
    step(1'b1, 3'd2, 16'h1234, 1'b0, '0, "wdis_wr");
    step(1'b0, 3'd2, 16'hFFFF, 1'b0, '0, "wdis_we0");
    step(1'b0, '0, '0, 1'b1, 3'd2, "wdis_rd");
    check_eq("wdis_const", dout, 16'h1234);

    // Collision on address 4
    step(1'b1, 3'd4, 16'h0004, 1'b0, '0, "col_pre");
    step(1'b1, 3'd4, 16'hBEEF, 1'b1, 3'd4, "col_same");
    check_eq("col_const", dout, Bypass ? 16'hBEEF : 16'h0004);
    step(1'b0, '0, '0, 1'b1, 3'd4, "col_after");
    check_eq("col_after_const", dout, 16'hBEEF);

    // Concurrent write i / read i-1
    step(1'b1, 3'd0, 16'h5A00, 1'b0, '0, "conc_w0");
    for (int i = 1; i < 8; i++) begin
      step(1'b1, AW'(i), 16'h5A00 + DW'(i), 1'b1, AW'(i - 1), "conc");
      check_eq("conc_const", dout, 16'h5A00 + DW'(i - 1));
    end

    // Reset mid-operation
    for (int i = 0; i < 8; i++) step(1'b1, AW'(i), 16'h00FF, 1'b0, '0, "rfill");
    step(1'b0, '0, '0, 1'b1, 3'd6, "rfill_rd");
    @(negedge clk);
    we = 1'b1; wr_addr = 3'd1; din = 16'h7777; re = 1'b1; rd_addr = 3'd1;
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_async", dout, '0);
    @(posedge clk);
    #1;
    check_eq("rst_held", dout, '0);
    @(negedge clk);
    rst = 1'b0; we = 1'b0; re = 1'b0;
    model_clear();
    for (int i = 0; i < 8; i++) begin
      step(1'b0, '0, '0, 1'b1, AW'(i), "rst_rd");
      check_eq("rst_rd_const", dout, '0);
    end

    // Randomized traffic, collisions biased in
    for (int n = 0; n < 400; n++) begin
      logic          w, r;
      logic [AW-1:0] wa, ra;
      logic [DW-1:0] d;
      w  = 1'($urandom_range(0, 1));
      r  = ($urandom_range(0, 3) != 0);
      wa = AW'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
      d  = DW'($urandom);
      step(w, wa, d, r, ra, "rand");
    end

    // Final sweep of the array
    for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b1, AW'(i), "sweep");
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
